// File: rtl/trig_event_uart_tx.sv
// Trigger event counter that sends each new count as a UART frame (8N1).
// Define TRIG_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module trig_event_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] event_cnt,
  output logic             overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(CNT_W + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef TRIG_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  logic par;
`endif

  logic [2:0]       state;
  logic [BW-1:0]    baud;
  logic [IW-1:0]    bit_idx;
  logic [CNT_W-1:0] shreg;
  logic [CNT_W-1:0] cnt_next;
  logic             pending;
  logic             baud_last;
  logic             last_bit;

  // the count sent always includes a trigger seen in the same cycle
  assign cnt_next  = event_cnt + {{(CNT_W-1){1'b0}}, trig_in};
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_idx == IW'(CNT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      pending   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      event_cnt <= '0;
      overflow  <= 1'b0;
`ifdef TRIG_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      event_cnt <= cnt_next;

      if (state == IDLE || baud_last)
        baud <= '0;
      else
        baud <= baud + 1'b1;

      if (trig_in && state != IDLE) begin
        if (!pending)
          pending <= 1'b1;
        else
          overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trig_in) begin
            shreg <= cnt_next;
`ifdef TRIG_TX_PARITY_EN
            par   <= ^cnt_next;
`endif
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (baud_last) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        DATA: begin
          if (baud_last) begin
            shreg <= shreg >> 1;
            if (last_bit) begin
`ifdef TRIG_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef TRIG_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            // a trigger on this exact cycle counts as pending and is consumed now
            if (pending || trig_in) begin
              pending <= 1'b0;
              shreg   <= cnt_next;
`ifdef TRIG_TX_PARITY_EN
              par     <= ^cnt_next;
`endif
              tx      <= 1'b0;
              state   <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_event_uart_tx.sv
// Directed bench for trig_event_uart_tx at CLKS_PER_BIT=4, CNT_W=8.
module tb_trig_event_uart_tx;

  localparam int CPB = 4;
`ifdef TRIG_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FT = NB * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig_in;
  logic       tx;
  logic       busy;
  logic [7:0] event_cnt;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  trig_event_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .trig_in(trig_in),
    .tx(tx),
    .busy(busy),
    .event_cnt(event_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse;
    trig_in = 1'b1;
    tick;
    trig_in = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  function automatic logic [10:0] mkf(input logic [7:0] d);
`ifdef TRIG_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // starts at cycle 0 of the start bit; trig_in high before tick k==t1/t2
  task automatic run_frame(input int t1, input int t2,
                           output logic [10:0] bits, output logic drop);
    bits = '0;
    drop = 1'b0;
    for (int k = 0; k < FT; k++) begin
      if (busy !== 1'b1) drop = 1'b1;
      if (k % CPB == CPB / 2) bits[k / CPB] = tx;
      trig_in = (k == t1) || (k == t2);
      tick;
    end
    trig_in = 1'b0;
  endtask

  logic [10:0] fr;
  logic        drop;
  logic        bad;

  initial begin
    rst = 1'b1;
    trig_in = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", event_cnt, 0);
    check("rst_ovf", overflow, 0);
    bad = 1'b0;
    repeat (50) begin
      tick;
      if (tx !== 1'b1 || busy !== 1'b0 || event_cnt !== 8'd0 ||
          overflow !== 1'b0) bad = 1'b1;
    end
    check("idle_quiet", bad, 0);

    repeat (10) tick;
    pulse;
    check("lat_busy", busy, 1);
    check("lat_tx", tx, 0);
    run_frame(-1, -1, fr, drop);
    check("single_frame", fr, mkf(8'h01));
    check("single_busy_held", drop, 0);
    check("single_busy_end", busy, 0);
    check("single_cnt", event_cnt, 1);

    do_reset;
    pulse;
    run_frame(7, -1, fr, drop);
    check("b2b_frame1", fr, mkf(8'h01));
    check("b2b_tx_low", tx, 0);
    check("b2b_busy", busy, 1);
    run_frame(-1, -1, fr, drop);
    check("b2b_frame2", fr, mkf(8'h02));
    check("b2b_no_gap", drop, 0);
    check("b2b_ovf", overflow, 0);
    check("b2b_busy_end", busy, 0);

    do_reset;
    pulse;
    run_frame(FT - 1, -1, fr, drop);
    check("edge_frame1", fr, mkf(8'h01));
    check("edge_tx_low", tx, 0);
    check("edge_busy", busy, 1);
    run_frame(-1, -1, fr, drop);
    check("edge_frame2", fr, mkf(8'h02));
    check("edge_ovf", overflow, 0);

    do_reset;
    pulse;
    run_frame(5, 9, fr, drop);
    check("ovf_frame1", fr, mkf(8'h01));
    check("ovf_set", overflow, 1);
    check("ovf_cnt", event_cnt, 3);
    run_frame(-1, -1, fr, drop);
    check("ovf_frame2", fr, mkf(8'h03));
    repeat (20) tick;
    check("ovf_sticky", overflow, 1);
    check("ovf_idle", busy, 0);
    do_reset;
    check("ovf_clr", overflow, 0);

    pulse;
    repeat (4 * CPB + 1) tick;
    check("mid_d3_tx", tx, 0);
    check("mid_d3_busy", busy, 1);
    do_reset;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_cnt", event_cnt, 0);
    repeat (5) tick;
    pulse;
    run_frame(-1, -1, fr, drop);
    check("abort_refr", fr, mkf(8'h01));
    check("abort_cnt1", event_cnt, 1);

    do_reset;
    for (int i = 1; i <= 255; i++) begin
      pulse;
      run_frame(-1, -1, fr, drop);
      check("wrap_pre", fr, mkf(8'(i)));
    end
    check("wrap_cnt255", event_cnt, 255);
    pulse;
    run_frame(-1, -1, fr, drop);
    check("wrap_frame", fr, mkf(8'h00));
    check("wrap_cnt0", event_cnt, 0);
    check("wrap_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trig_event_uart_tx.md
Name: trig_event_uart_tx

Overview:
- Sits directly downstream of the delayed-pulse stage and consumes its one-cycle `signal` output as `trig_in`.
- Counts trigger events and serializes each new event count as an 8N1 UART frame on `tx` for host-side logging.
- Triggers that arrive while a frame is in flight are queued one deep; any excess sets a sticky overflow flag.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- CNT_W, 8, width of the event counter and of the data field per frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- trig_in  in  1  one-cycle trigger pulse, already synchronous to clk.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high while a frame (start through stop) is on the line.
- event_cnt  out  CNT_W  running count of accepted triggers.
- overflow  out  1  sticky; set when a trigger is lost.

Behaviour:
- Reset (rst high at an edge):
  - tx=1, busy=0, event_cnt=0, overflow=0.
  - FSM goes to IDLE; pending flag, bit counter and baud counter are cleared.
  - A reset mid-frame aborts the frame; tx is 1 from the next cycle.
- Event counter:
  - Increments by 1 on every cycle with trig_in=1, in any state.
  - Wraps modulo 2^CNT_W (255 -> 0).
  - The value sent in a frame is event_cnt after the increment caused by the launching trigger.
- FSM states IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - trig_in=1 at edge N: load shift register with event_cnt+1 and go to START.
  - tx=0 and busy=1 from cycle N+1, so latency is 1 clock.
- Each bit is held for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
- START: tx=0 for one bit time, then DATA.
- DATA: CNT_W bits, LSB first, then STOP.
- STOP: tx=1 for one bit time. On the final cycle of STOP:
  - pending=1: clear pending, reload shift register with current event_cnt (including any same-cycle trigger), go to START. tx goes low next cycle and busy stays high, giving a back-to-back frame.
  - pending=0: go to IDLE; busy=0 next cycle.
- trig_in=1 while not IDLE:
  - pending=0: set pending.
  - pending=1: set overflow.
  - Counter increments in both cases.
- Trigger coinciding with the last STOP cycle:
  - Counts as arriving while busy, so it sets pending, which is consumed in that same cycle.
  - It therefore produces a back-to-back frame, not an overflow.
- overflow is cleared only by rst.
- Frame length is (CNT_W+2)*CLKS_PER_BIT cycles (10*CLKS_PER_BIT at the default width).
- tx is driven from a register; no combinational path from trig_in to tx.

Optional Feature:
- Macro: TRIG_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - The parity bit is even parity (XOR of the CNT_W data bits), held for one bit time.
  - Frame becomes 8E1, length (CNT_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1 framing, length (CNT_W+2)*CLKS_PER_BIT.

Test Plan (CLKS_PER_BIT=4, CNT_W=8, macro undefined unless stated):
- Reset then idle 50 cycles -> tx=1, busy=0, event_cnt=0, overflow=0 throughout.
- Single trig_in pulse at cycle 10 -> busy=1 at cycle 11. tx sequence, 4 cycles per bit: 0, 1, 0,0,0,0,0,0,0, 1, i.e. byte 0x01 LSB first. busy=0 at cycle 51; event_cnt=1.
- Two pulses 8 cycles apart -> first frame sends 0x01. Second frame starts with no idle gap: tx low on the cycle after the last stop cycle, busy never drops, and it sends 0x02. overflow=0.
- Three pulses within one frame -> frames 0x01 then 0x03, overflow=1, event_cnt=3. overflow remains 1 until rst.
- Preload 255 triggers spaced one frame apart, then one more -> last frame sends 0x00, event_cnt=0 (wrap).
- Assert rst during DATA bit 3 -> tx=1 and busy=0 next cycle, event_cnt=0. A trigger 5 cycles later sends 0x01 normally.
- With TRIG_TX_PARITY_EN: single trigger, count 0x03 -> parity bit 0 between data and stop. Frame lasts 44 cycles.
